// File: rtl/calc2_engine.sv
// ----------------------------------------------------------------------------
// calc2_engine
//   Four-port tagged integer calculator. Each requester port issues
//   add/sub/shift commands with a 2-bit tag. One shared add/sub unit and one
//   shared shift unit execute them. Each result returns on the port that
//   issued the request, with that request's tag.
//
// Ports
//   c_clk                 clock, all state on rising edge
//   reset                 asynchronous active-low reset
//   reqN_cmd_in  [3:0]    N=1..4: 0 none, 1 ADD, 2 SUB, 5 SHL, 6 SHR, others invalid
//   reqN_data_in [31:0]   operand1 in the command cycle, operand2 in the next cycle
//   reqN_tag_in  [1:0]    request tag, sampled in the command cycle
//   out_respN    [1:0]    0 none, 1 success, 2 overflow/underflow/invalid
//   out_dataN    [31:0]   result, 0 unless out_respN == 1
//   out_tagN     [1:0]    tag of the request being answered
//   dbg_cap_state_o [7:0] capture FSM state of each port, 2 bits per port
//                         (port1 in [1:0] ... port4 in [7:6])
//
// Request protocol (there is no ready/back-pressure): a port presents
// cmd != 0 with tag and operand1 for one cycle, then operand2 in the next
// cycle. The following cycle is a commit cycle in which cmd is ignored, so a
// new command is accepted two edges after operand2 was sampled. A command
// whose tag is still outstanding on that port is consumed and then dropped
// with no response.
//
// Pipeline, for operand2 latched at edge E:
//   E+1  request written into the per-port pending buffer (commit)
//   E+2  arbiter moves it into the add/sub or shift stage register
//   E+3  result registered on the port outputs, held for one cycle
// ----------------------------------------------------------------------------
module calc2_engine (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4,
  output logic [7:0]  dbg_cap_state_o
);

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_OP2    = 2'd1,
    CAP_COMMIT = 2'd2
  } cap_state_e;

  // Input bundling so per-port logic can be written as loops
  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  tag_in  [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;
  assign tag_in[0]  = req1_tag_in;
  assign tag_in[1]  = req2_tag_in;
  assign tag_in[2]  = req3_tag_in;
  assign tag_in[3]  = req4_tag_in;

  // Capture path
  cap_state_e  cap_state_q [4];
  cap_state_e  cap_state_d [4];
  logic [3:0]  cap_cmd_q   [4];
  logic [1:0]  cap_tag_q   [4];
  logic [31:0] cap_op1_q   [4];
  logic [31:0] cap_op2_q   [4];
  logic        cap_drop_q  [4];
  logic        tag_busy    [4];
  logic        commit      [4];

  // Pending buffer, indexed by tag. older_q[p][i][j] = entry i older than j.
  logic [3:0]       pend_v_q   [4];
  logic [3:0]       pend_v_d   [4];
  logic [3:0][3:0]  older_q    [4];
  logic [3:0][3:0]  older_d    [4];
  logic [3:0]       pend_cmd_q [4][4];
  logic [31:0]      pend_op1_q [4][4];
  logic [31:0]      pend_op2_q [4][4];

  // Arbitration
  logic [3:0] add_m [4];
  logic [3:0] shf_m [4];
  logic [3:0] add_req;
  logic [3:0] shf_req;
  logic [3:0] shf_mask;
  logic       add_gnt_v;
  logic [1:0] add_port;
  logic [1:0] add_tag;
  logic       shf_gnt_v;
  logic [1:0] shf_port;
  logic [1:0] shf_tag;
  logic [1:0] add_last_q;
  logic [1:0] shf_last_q;

  // Execution stages
  logic        as_v_q;
  logic [1:0]  as_port_q;
  logic [1:0]  as_tag_q;
  logic [3:0]  as_cmd_q;
  logic [31:0] as_op1_q;
  logic [31:0] as_op2_q;
  logic        ss_v_q;
  logic [1:0]  ss_port_q;
  logic [1:0]  ss_tag_q;
  logic        ss_left_q;
  logic [31:0] ss_op1_q;
  logic [4:0]  ss_amt_q;

  // Results / outputs
  logic [32:0] sum;
  logic [1:0]  add_resp;
  logic [31:0] add_data;
  logic [31:0] shf_data;
  logic [1:0]  out_resp_q [4];
  logic [1:0]  out_resp_d [4];
  logic [31:0] out_data_q [4];
  logic [31:0] out_data_d [4];
  logic [1:0]  out_tag_q  [4];
  logic [1:0]  out_tag_d  [4];

  // Oldest entry in mask m: the one no other masked entry is older than.
  function automatic logic [1:0] pick_oldest(input logic [3:0] m,
                                             input logic [3:0][3:0] older);
    logic [1:0] r;
    logic       blocked;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (m[j] && older[j][i]) blocked = 1'b1;
      end
      if (m[i] && !blocked) r = 2'(i);
    end
    return r;
  endfunction

  // Round-robin starting after 'last'; scanning from far to near so the
  // nearest requester wins. Returns {found, port}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- capture
  // A tag is outstanding while pending or sitting in either execution stage.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      tag_busy[p] = pend_v_q[p][tag_in[p]]
                  | (as_v_q && as_port_q == 2'(p) && as_tag_q == tag_in[p])
                  | (ss_v_q && ss_port_q == 2'(p) && ss_tag_q == tag_in[p]);
      commit[p]   = (cap_state_q[p] == CAP_COMMIT) && !cap_drop_q[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      cap_state_d[p] = cap_state_q[p];
      case (cap_state_q[p])
        CAP_IDLE:   if (cmd_in[p] != CMD_NONE) cap_state_d[p] = CAP_OP2;
        CAP_OP2:    cap_state_d[p] = CAP_COMMIT;
        CAP_COMMIT: cap_state_d[p] = CAP_IDLE;
        default:    cap_state_d[p] = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        cap_state_q[p] <= CAP_IDLE;
        cap_cmd_q[p]   <= '0;
        cap_tag_q[p]   <= '0;
        cap_op1_q[p]   <= '0;
        cap_op2_q[p]   <= '0;
        cap_drop_q[p]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        cap_state_q[p] <= cap_state_d[p];
        if (cap_state_q[p] == CAP_IDLE && cmd_in[p] != CMD_NONE) begin
          cap_cmd_q[p]  <= cmd_in[p];
          cap_tag_q[p]  <= tag_in[p];
          cap_op1_q[p]  <= data_in[p];
          cap_drop_q[p] <= tag_busy[p];
        end
        if (cap_state_q[p] == CAP_OP2) cap_op2_q[p] <= data_in[p];
      end
    end
  end

  // ------------------------------------------------------------ arbitration
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 4; t++) begin
        add_m[p][t] = pend_v_q[p][t] &&
                      !(pend_cmd_q[p][t] == CMD_SHL || pend_cmd_q[p][t] == CMD_SHR);
        shf_m[p][t] = pend_v_q[p][t] &&
                      (pend_cmd_q[p][t] == CMD_SHL || pend_cmd_q[p][t] == CMD_SHR);
      end
      add_req[p] = |add_m[p];
      shf_req[p] = |shf_m[p];
    end
    {add_gnt_v, add_port} = rr_pick(add_req, add_last_q);
    // Keep each port to one result per cycle.
    shf_mask = shf_req;
    if (add_gnt_v) shf_mask[add_port] = 1'b0;
    {shf_gnt_v, shf_port} = rr_pick(shf_mask, shf_last_q);
    add_tag = pick_oldest(add_m[add_port], older_q[add_port]);
    shf_tag = pick_oldest(shf_m[shf_port], older_q[shf_port]);
  end

  // ------------------------------------------------------- pending buffer
  always_comb begin
    pend_v_d = pend_v_q;
    older_d  = older_q;
    for (int p = 0; p < 4; p++) begin
      if (add_gnt_v && add_port == 2'(p)) pend_v_d[p][add_tag] = 1'b0;
      if (shf_gnt_v && shf_port == 2'(p)) pend_v_d[p][shf_tag] = 1'b0;
      if (commit[p]) begin
        pend_v_d[p][cap_tag_q[p]] = 1'b1;
        // Everything already present is older than the new entry.
        for (int j = 0; j < 4; j++) begin
          older_d[p][j][cap_tag_q[p]] = pend_v_q[p][j];
          older_d[p][cap_tag_q[p]][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        pend_v_q[p] <= '0;
        older_q[p]  <= '0;
        for (int t = 0; t < 4; t++) begin
          pend_cmd_q[p][t] <= '0;
          pend_op1_q[p][t] <= '0;
          pend_op2_q[p][t] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        pend_v_q[p] <= pend_v_d[p];
        older_q[p]  <= older_d[p];
        if (commit[p]) begin
          pend_cmd_q[p][cap_tag_q[p]] <= cap_cmd_q[p];
          pend_op1_q[p][cap_tag_q[p]] <= cap_op1_q[p];
          pend_op2_q[p][cap_tag_q[p]] <= cap_op2_q[p];
        end
      end
    end
  end

  // ------------------------------------------------------ execution stages
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      add_last_q <= 2'd3;
      shf_last_q <= 2'd3;
      as_v_q     <= 1'b0;
      as_port_q  <= '0;
      as_tag_q   <= '0;
      as_cmd_q   <= '0;
      as_op1_q   <= '0;
      as_op2_q   <= '0;
      ss_v_q     <= 1'b0;
      ss_port_q  <= '0;
      ss_tag_q   <= '0;
      ss_left_q  <= 1'b0;
      ss_op1_q   <= '0;
      ss_amt_q   <= '0;
    end else begin
      as_v_q <= add_gnt_v;
      if (add_gnt_v) begin
        add_last_q <= add_port;
        as_port_q  <= add_port;
        as_tag_q   <= add_tag;
        as_cmd_q   <= pend_cmd_q[add_port][add_tag];
        as_op1_q   <= pend_op1_q[add_port][add_tag];
        as_op2_q   <= pend_op2_q[add_port][add_tag];
      end
      ss_v_q <= shf_gnt_v;
      if (shf_gnt_v) begin
        shf_last_q <= shf_port;
        ss_port_q  <= shf_port;
        ss_tag_q   <= shf_tag;
        ss_left_q  <= (pend_cmd_q[shf_port][shf_tag] == CMD_SHL);
        ss_op1_q   <= pend_op1_q[shf_port][shf_tag];
        ss_amt_q   <= pend_op2_q[shf_port][shf_tag][4:0];
      end
    end
  end

  // --------------------------------------------------------------- results
  always_comb begin
    sum      = {1'b0, as_op1_q} + {1'b0, as_op2_q};
    add_resp = RESP_ERR;
    add_data = '0;
    case (as_cmd_q)
      CMD_ADD: begin
        if (!sum[32]) begin
          add_resp = RESP_OK;
          add_data = sum[31:0];
        end
      end
      CMD_SUB: begin
        if (as_op2_q <= as_op1_q) begin
          add_resp = RESP_OK;
          add_data = as_op1_q - as_op2_q;
        end
      end
      default: ;
    endcase
    shf_data = ss_left_q ? (ss_op1_q << ss_amt_q) : (ss_op1_q >> ss_amt_q);

    for (int p = 0; p < 4; p++) begin
      out_resp_d[p] = RESP_NONE;
      out_data_d[p] = '0;
      out_tag_d[p]  = '0;
      if (as_v_q && as_port_q == 2'(p)) begin
        out_resp_d[p] = add_resp;
        out_data_d[p] = add_data;
        out_tag_d[p]  = as_tag_q;
      end else if (ss_v_q && ss_port_q == 2'(p)) begin
        out_resp_d[p] = RESP_OK;
        out_data_d[p] = shf_data;
        out_tag_d[p]  = ss_tag_q;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        out_resp_q[p] <= RESP_NONE;
        out_data_q[p] <= '0;
        out_tag_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        out_resp_q[p] <= out_resp_d[p];
        out_data_q[p] <= out_data_d[p];
        out_tag_q[p]  <= out_tag_d[p];
      end
    end
  end

  assign out_resp1 = out_resp_q[0];
  assign out_data1 = out_data_q[0];
  assign out_tag1  = out_tag_q[0];
  assign out_resp2 = out_resp_q[1];
  assign out_data2 = out_data_q[1];
  assign out_tag2  = out_tag_q[1];
  assign out_resp3 = out_resp_q[2];
  assign out_data3 = out_data_q[2];
  assign out_tag3  = out_tag_q[2];
  assign out_resp4 = out_resp_q[3];
  assign out_data4 = out_data_q[3];
  assign out_tag4  = out_tag_q[3];

  assign dbg_cap_state_o = {cap_state_q[3], cap_state_q[2],
                            cap_state_q[1], cap_state_q[0]};

endmodule

// File: tb/tb_calc2_engine.sv
// ----------------------------------------------------------------------------
// tb_calc2_engine
//   Directed test of calc2_engine. A negedge monitor records every non-idle
//   output as {port, resp, tag, data, cycle}; each step pushes the hand
//   computed responses into exp_q and drain() compares the two in order.
// ----------------------------------------------------------------------------
module tb_calc2_engine;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] SHL = 4'd5;
  localparam logic [3:0] SHR = 4'd6;

  // Clock / reset
  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Drive side
  logic [3:0]  drv_cmd  [4];
  logic [1:0]  drv_tag  [4];
  logic [31:0] drv_data [4];
  logic [31:0] op2_buf  [4];
  logic [3:0]  active;

  // Observe side
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic [1:0]  o_tag  [4];
  logic [7:0]  dbg;

  calc2_engine dut (
    .c_clk           (c_clk),
    .reset           (reset),
    .req1_cmd_in     (drv_cmd[0]),
    .req1_data_in    (drv_data[0]),
    .req1_tag_in     (drv_tag[0]),
    .req2_cmd_in     (drv_cmd[1]),
    .req2_data_in    (drv_data[1]),
    .req2_tag_in     (drv_tag[1]),
    .req3_cmd_in     (drv_cmd[2]),
    .req3_data_in    (drv_data[2]),
    .req3_tag_in     (drv_tag[2]),
    .req4_cmd_in     (drv_cmd[3]),
    .req4_data_in    (drv_data[3]),
    .req4_tag_in     (drv_tag[3]),
    .out_resp1       (o_resp[0]),
    .out_data1       (o_data[0]),
    .out_tag1        (o_tag[0]),
    .out_resp2       (o_resp[1]),
    .out_data2       (o_data[1]),
    .out_tag2        (o_tag[1]),
    .out_resp3       (o_resp[2]),
    .out_data3       (o_data[2]),
    .out_tag3        (o_tag[2]),
    .out_resp4       (o_resp[3]),
    .out_data4       (o_data[3]),
    .out_tag4        (o_tag[3]),
    .dbg_cap_state_o (dbg)
  );

  // Scoreboard: {port[1:0], resp[1:0], tag[1:0], data[31:0], cycle[15:0]}
  logic [53:0] exp_q[$];
  logic [53:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Any non-zero output field is recorded, so stray data/tag on an idle
  // port also shows up as an unexpected entry.
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      if (o_resp[p] != 2'd0 || o_data[p] != 32'd0 || o_tag[p] != 2'd0)
        got_q.push_back({2'(p), o_resp[p], o_tag[p], o_data[p], 16'(cyc)});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_drv();
    for (int p = 0; p < 4; p++) begin
      drv_cmd[p]  = '0;
      drv_tag[p]  = '0;
      drv_data[p] = '0;
      op2_buf[p]  = '0;
    end
    active = '0;
  endtask

  task automatic load(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                      input logic [31:0] op1, input logic [31:0] op2);
    drv_cmd[p]  = cmd;
    drv_tag[p]  = tag;
    drv_data[p] = op1;
    op2_buf[p]  = op2;
    active[p]   = 1'b1;
  endtask

  // Command edge, operand2 edge (returned in e), then the commit cycle.
  task automatic launch(output int e);
    tick();
    for (int p = 0; p < 4; p++) begin
      if (active[p]) begin
        drv_cmd[p]  = '0;
        drv_tag[p]  = '0;
        drv_data[p] = op2_buf[p];
      end
    end
    tick();
    e = cyc;
    clear_drv();
    tick();
  endtask

  task automatic issue(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] op1, input logic [31:0] op2, output int e);
    load(p, cmd, tag, op1, op2);
    launch(e);
  endtask

  task automatic expect_rsp(input int p, input logic [1:0] resp, input logic [1:0] tag,
                            input logic [31:0] data, input int c);
    exp_q.push_back({2'(p), resp, tag, data, 16'(c)});
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drain(input string name);
    int i;
    repeat (10) tick();
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    i = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk($sformatf("%s_rsp%0d", name, i), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      i++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic chk_outputs_idle(input string name);
    for (int p = 0; p < 4; p++)
      chk($sformatf("%s_p%0d", name, p + 1), 64'({o_resp[p], o_tag[p], o_data[p]}), 64'd0);
  endtask

  initial begin
    int e;
    clear_drv();
    reset = 1'b0;
    repeat (3) tick();
    chk_outputs_idle("reset_out");
    reset = 1'b1;
    tick();

    // Basic ADD, latency 3 edges after operand2
    issue(0, ADD, 2'd2, 32'h10, 32'd11, e);
    expect_rsp(0, 2'd1, 2'd2, 32'h1B, e + 3);
    drain("add_basic");

    // Overflow, underflow, equal and plain subtraction
    issue(0, ADD, 2'd1, 32'hFFFF_FFFF, 32'h1, e);
    expect_rsp(0, 2'd2, 2'd1, 32'h0, e + 3);
    issue(1, SUB, 2'd0, 32'd5, 32'd6, e);
    expect_rsp(1, 2'd2, 2'd0, 32'h0, e + 3);
    issue(1, SUB, 2'd1, 32'd6, 32'd6, e);
    expect_rsp(1, 2'd1, 2'd1, 32'h0, e + 3);
    issue(1, SUB, 2'd2, 32'd9, 32'd4, e);
    expect_rsp(1, 2'd1, 2'd2, 32'd5, e + 3);
    drain("addsub");

    // Shifts (amount is op2[4:0]) and an invalid command on the add path
    issue(2, SHL, 2'd3, 32'h1, 32'd31, e);
    expect_rsp(2, 2'd1, 2'd3, 32'h8000_0000, e + 3);
    issue(2, SHL, 2'd0, 32'h1, 32'h21, e);
    expect_rsp(2, 2'd1, 2'd0, 32'h2, e + 3);
    issue(3, SHR, 2'd1, 32'h8000_0000, 32'd4, e);
    expect_rsp(3, 2'd1, 2'd1, 32'h0800_0000, e + 3);
    issue(3, SHR, 2'd2, 32'hF0, 32'hFFFF_FFE4, e);
    expect_rsp(3, 2'd1, 2'd2, 32'hF, e + 3);
    issue(3, 4'd7, 2'd3, 32'h55, 32'h66, e);
    expect_rsp(3, 2'd2, 2'd3, 32'h0, e + 3);
    drain("shift_inv");

    // Four ADDs at once; last add grant was port4, so order is 1,2,3,4
    for (int p = 0; p < 4; p++) load(p, ADD, 2'(p), 32'h100 * (p + 1), 32'(p + 1));
    launch(e);
    for (int p = 0; p < 4; p++)
      expect_rsp(p, 2'd1, 2'(p), 32'h101 * (p + 1), e + 3 + p);
    drain("rr_all4");

    // ADD and SHL on different ports finish in the same cycle
    load(0, ADD, 2'd0, 32'd1, 32'd2);
    load(1, SHL, 2'd0, 32'd3, 32'd2);
    launch(e);
    expect_rsp(0, 2'd1, 2'd0, 32'd3, e + 3);
    expect_rsp(1, 2'd1, 2'd0, 32'd12, e + 3);
    drain("add_shl_par");

    // Last add grant now port1, so rotation starts at port2
    for (int p = 0; p < 4; p++) load(p, ADD, 2'(p), 32'h100 * (p + 1), 32'(p + 1));
    launch(e);
    expect_rsp(1, 2'd1, 2'd1, 32'h202, e + 3);
    expect_rsp(2, 2'd1, 2'd2, 32'h303, e + 4);
    expect_rsp(3, 2'd1, 2'd3, 32'h404, e + 5);
    expect_rsp(0, 2'd1, 2'd0, 32'h101, e + 6);
    drain("rr_rotate");

    // Tags 0..3 back-to-back on port2, then an immediate reuse of tag 0
    for (int t = 0; t < 4; t++) begin
      issue(1, ADD, 2'(t), 32'h1000 * (t + 1), 32'(t), e);
      expect_rsp(1, 2'd1, 2'(t), 32'h1000 * (t + 1) + 32'(t), e + 3);
    end
    issue(1, ADD, 2'd0, 32'hA, 32'hB, e);
    expect_rsp(1, 2'd1, 2'd0, 32'h15, e + 3);
    issue(1, ADD, 2'd0, 32'hC, 32'hD, e);
    drain("tags_reuse");

    // Reset between command and operand2
    load(0, ADD, 2'd0, 32'h1234, 32'h1);
    tick();
    chk("cap_state_op2", 64'(dbg[1:0]), 64'd1);
    reset = 1'b0;
    clear_drv();
    tick();
    tick();
    chk_outputs_idle("midreset_out");
    chk("cap_state_reset", 64'(dbg), 64'd0);
    reset = 1'b1;
    drain("midreset_nores");
    issue(0, ADD, 2'd3, 32'h30, 32'h20, e);
    expect_rsp(0, 2'd1, 2'd3, 32'h50, e + 3);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
